// File: rtl/ad9361_patgen_pkg.sv
// rtl/ad9361_patgen_pkg.sv - shared constants and state type for the AD9361 RX pattern generator
package ad9361_patgen_pkg;

    localparam logic [1:0] PAT_RAMP  = 2'b00;
    localparam logic [1:0] PAT_PN9   = 2'b01;
    localparam logic [1:0] PAT_CONST = 2'b10;
    localparam logic [1:0] PAT_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10
    } state_t;

    localparam int FRAME_NIB_1R = 4;
    localparam int FRAME_NIB_2R = 8;

    // x^9 + x^5 + 1: feedback taken from bits 8 and 4 of a left-shifting register
    localparam logic [8:0] PN9_SEED = 9'h1FF;
    localparam logic [8:0] PN9_TAPS = 9'h110;

endpackage

// File: rtl/ad9361_patgen_pn9.sv
// rtl/ad9361_patgen_pn9.sv - PN9 LFSR yielding one WORD_W-bit word (first bit in MSB) per advance
module ad9361_patgen_pn9
    import ad9361_patgen_pkg::*;
#(
    parameter int WORD_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    output logic [WORD_W-1:0] word
);

    logic [8:0] lfsr_q;
    logic [8:0] lfsr_d;
    logic [8:0] lfsr_nxt;

    always_comb begin
        lfsr_nxt = lfsr_q;
        word     = '0;
        for (int i = 0; i < WORD_W; i++) begin
            word     = {word[WORD_W-2:0], lfsr_nxt[8]};
            lfsr_nxt = {lfsr_nxt[7:0], ^(lfsr_nxt & PN9_TAPS)};
        end
        lfsr_d = advance ? lfsr_nxt : lfsr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= PN9_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/ad9361_rx_pattern_gen.sv
// rtl/ad9361_rx_pattern_gen.sv - nibble-serial AD9361 RX frame source; PN9 mode under AD9361_PATGEN_PN_EN
module ad9361_rx_pattern_gen
    import ad9361_patgen_pkg::*;
#(
    parameter int                DATA_W    = 12,
    parameter int                NIB_W     = 6,
    parameter logic [DATA_W-1:0] RAMP_INIT = 12'h000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              r1_mode,
    input  logic [1:0]        pattern_mode,
    input  logic [DATA_W-1:0] const_i,
    input  logic [DATA_W-1:0] const_q,
    output logic              rx_frame,
    output logic [NIB_W-1:0]  rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    localparam logic [DATA_W-1:0] RAMP_FLIP = DATA_W'(1) << (DATA_W - 1);

    state_t            state_q, state_d;
    logic [2:0]        nib_idx_q, nib_idx_d;
    logic              r1_q, r1_d;
    logic [1:0]        pat_q, pat_d;
    logic [DATA_W-1:0] ci_q, ci_d;
    logic [DATA_W-1:0] cq_q, cq_d;
    logic [DATA_W-1:0] ramp_q, ramp_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              rx_frame_q, rx_frame_d;
    logic [NIB_W-1:0]  rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    logic              latch;
    logic              frame_last;
    logic              pn_adv;
    logic [1:0]        word_idx;
    logic [DATA_W-1:0] cur_word;

`ifdef AD9361_PATGEN_PN_EN
    logic [DATA_W-1:0] pn_word;

    ad9361_patgen_pn9 #(
        .WORD_W (DATA_W)
    ) u_pn9 (
        .clk     (clk),
        .rst     (rst),
        .advance (pn_adv),
        .word    (pn_word)
    );
`endif

    // Word order within a frame is I0, Q0, I1, Q1; 1R1T frames stop after Q0.
    assign word_idx = nib_idx_q[2:1];

    always_comb begin
        cur_word = '0;
        case (pat_q)
            PAT_RAMP: begin
                case (word_idx)
                    2'd0:    cur_word = ramp_q;
                    2'd1:    cur_word = ~ramp_q;
                    2'd2:    cur_word = ramp_q ^ RAMP_FLIP;
                    default: cur_word = ~(ramp_q ^ RAMP_FLIP);
                endcase
            end
`ifdef AD9361_PATGEN_PN_EN
            PAT_PN9:   cur_word = pn_word;
`endif
            PAT_CONST: cur_word = word_idx[0] ? cq_q : ci_q;
            default:   cur_word = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        nib_idx_d   = nib_idx_q;
        r1_d        = r1_q;
        pat_d       = pat_q;
        ci_d        = ci_q;
        cq_d        = cq_q;
        ramp_d      = ramp_q;
        hold_d      = hold_q;
        frame_cnt_d = frame_cnt_q;
        rx_frame_d  = rx_frame_q;
        rx_data_d   = '0;
        rx_valid_d  = 1'b0;
        latch       = 1'b0;
        pn_adv      = 1'b0;
        frame_last  = (nib_idx_q == (r1_q ? 3'(FRAME_NIB_1R - 1) : 3'(FRAME_NIB_2R - 1)));

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = RUN;
                    nib_idx_d = '0;
                    latch     = 1'b1;
                end
            end
            RUN, STOP: begin
                rx_valid_d = 1'b1;
                rx_frame_d = r1_q ? ~nib_idx_q[1] : ~nib_idx_q[2];
                // MSB half is emitted straight from the word; LSB half from the copy kept here
                if (nib_idx_q[0]) begin
                    rx_data_d = hold_q[NIB_W-1:0];
                end else begin
                    rx_data_d = cur_word[DATA_W-1:NIB_W];
                    hold_d    = cur_word;
`ifdef AD9361_PATGEN_PN_EN
                    pn_adv    = (pat_q == PAT_PN9);
`endif
                end
                if (frame_last) begin
                    nib_idx_d   = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (pat_q == PAT_RAMP) begin
                        ramp_d = ramp_q + DATA_W'(1);
                    end
                    state_d = enable ? RUN : IDLE;
                    latch   = enable;
                end else begin
                    nib_idx_d = nib_idx_q + 3'd1;
                    state_d   = enable ? RUN : STOP;
                end
            end
            default: state_d = IDLE;
        endcase

        if (latch) begin
            r1_d  = r1_mode;
            pat_d = pattern_mode;
            ci_d  = const_i;
            cq_d  = const_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            nib_idx_q   <= '0;
            r1_q        <= 1'b0;
            pat_q       <= PAT_RAMP;
            ci_q        <= '0;
            cq_q        <= '0;
            ramp_q      <= RAMP_INIT;
            hold_q      <= '0;
            frame_cnt_q <= '0;
            rx_frame_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_idx_q   <= nib_idx_d;
            r1_q        <= r1_d;
            pat_q       <= pat_d;
            ci_q        <= ci_d;
            cq_q        <= cq_d;
            ramp_q      <= ramp_d;
            hold_q      <= hold_d;
            frame_cnt_q <= frame_cnt_d;
            rx_frame_q  <= rx_frame_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    assign rx_frame  = rx_frame_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_ad9361_rx_pattern_gen.sv
// tb/tb_ad9361_rx_pattern_gen.sv - scoreboard bench for ad9361_rx_pattern_gen
module tb_ad9361_rx_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        r1_mode;
    logic [1:0]  pattern_mode;
    logic [11:0] const_i;
    logic [11:0] const_q;
    logic        rx_frame;
    logic [5:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic [15:0] frame_cnt;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [6:0]  exp_q[$];
    logic [11:0] m_ramp;
    logic [8:0]  m_pn;
    int          exp_frames;

    localparam logic [1:0] M_RAMP  = 2'b00;
    localparam logic [1:0] M_PN    = 2'b01;
    localparam logic [1:0] M_CONST = 2'b10;
    localparam logic [1:0] M_RSVD  = 2'b11;
`ifdef AD9361_PATGEN_PN_EN
    localparam logic [1:0] P6 = M_PN;
`else
    localparam logic [1:0] P6 = M_RAMP;
`endif

    ad9361_rx_pattern_gen dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .r1_mode      (r1_mode),
        .pattern_mode (pattern_mode),
        .const_i      (const_i),
        .const_q      (const_q),
        .rx_frame     (rx_frame),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic pn_next(output logic [11:0] w);
        w = '0;
        for (int b = 0; b < 12; b++) begin
            w    = {w[10:0], m_pn[8]};
            m_pn = {m_pn[7:0], m_pn[8] ^ m_pn[4]};
        end
    endtask

    task automatic push_frames(input logic r1, input logic [1:0] pat,
                               input logic [11:0] ci, input logic [11:0] cq, input int n);
        logic [11:0] w[4];
        logic        fr;
        int          nw;
        for (int f = 0; f < n; f++) begin
            nw = r1 ? 2 : 4;
            for (int j = 0; j < 4; j++) w[j] = '0;
            case (pat)
                M_RAMP: begin
                    w[0] = m_ramp;
                    w[1] = ~m_ramp;
                    w[2] = m_ramp ^ 12'h800;
                    w[3] = ~w[2];
                    m_ramp = m_ramp + 12'd1;
                end
                M_CONST: begin
                    w[0] = ci; w[1] = cq; w[2] = ci; w[3] = cq;
                end
`ifdef AD9361_PATGEN_PN_EN
                M_PN: for (int j = 0; j < nw; j++) pn_next(w[j]);
`endif
                default: ;
            endcase
            for (int j = 0; j < nw; j++) begin
                fr = r1 ? (j == 0) : (j < 2);
                exp_q.push_back({fr, w[j][11:6]});
                exp_q.push_back({fr, w[j][5:0]});
            end
            exp_frames++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_frame"}, rx_frame, 0);
        chk({tag, "_data"}, rx_data, 0);
        chk({tag, "_valid"}, rx_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fcnt"}, frame_cnt, 0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ramp     = 12'h000;
        m_pn       = 9'h1FF;
        exp_frames = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        chk_reset_vals("rst");
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        chk("idle", busy, 0);
        @(negedge clk);
        #1;
        chk("valid_off", rx_valid, 0);
        chk("data_off", rx_data, 0);
        chk("sb_drained", exp_q.size(), 0);
        chk("frame_cnt", frame_cnt, exp_frames);
    endtask

    task automatic run(input logic r1, input logic [1:0] pat, input logic [11:0] ci,
                       input logic [11:0] cq, input int n, input bit lat);
        int len;
        len = (r1 ? 4 : 8) * n;
        push_frames(r1, pat, ci, cq, n);
        @(negedge clk);
        r1_mode = r1; pattern_mode = pat; const_i = ci; const_q = cq; enable = 1'b1;
        @(negedge clk);
        if (lat) begin
            chk("lat_valid", rx_valid, 0);
            chk("lat_busy", busy, 1);
        end
        repeat (len - 1) @(negedge clk);
        enable = 1'b0;
        wait_idle();
    endtask

    // Scoreboard consumer: every live nibble must match the next expected one
    always @(negedge clk) begin
        logic [6:0] e;
        if (!rst && rx_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_extra", rx_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("nib", {rx_frame, rx_data}, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; r1_mode = 1'b1; pattern_mode = M_RAMP;
        const_i = '0; const_q = '0;
        reset_dut();

        // 1R1T ramp: first frame 00,00,3F,3F then I=001
        run(1'b1, M_RAMP, 12'h0, 12'h0, 1, 1'b1);
        run(1'b1, M_RAMP, 12'h0, 12'h0, 1, 1'b1);

        // 2R2T constant, reserved, and mode 01
        run(1'b0, M_CONST, 12'hABC, 12'h123, 2, 1'b0);
        run(1'b0, M_RSVD, 12'hABC, 12'h123, 1, 1'b0);
        run(1'b0, M_PN, 12'hABC, 12'h123, 1, 1'b0);

        // Ramp wrap over 4097 frames
        reset_dut();
        run(1'b1, M_RAMP, 12'h0, 12'h0, 4097, 1'b0);

        // Enable dropped after nibble 1 of a 2R2T frame
        reset_dut();
        push_frames(1'b0, M_RAMP, 12'h0, 12'h0, 1);
        @(negedge clk);
        r1_mode = 1'b0; pattern_mode = M_RAMP; enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        wait_idle();
        chk("stop_frame_hold", rx_frame, 0);

        // Re-assert during STOP: two frames with no gap
        push_frames(1'b0, M_RAMP, 12'h0, 12'h0, 2);
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i >= 2) chk("cont_valid", rx_valid, 1);
            enable = (i <= 2) || (i >= 5 && i <= 15);
        end
        wait_idle();

        // r1_mode changed mid-frame takes effect at the frame boundary
        push_frames(1'b1, M_RAMP, 12'h0, 12'h0, 1);
        push_frames(1'b0, M_RAMP, 12'h0, 12'h0, 1);
        @(negedge clk);
        r1_mode = 1'b1; pattern_mode = M_RAMP; enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        r1_mode = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        wait_idle();

        // rst mid-frame while enabled, then restart
        reset_dut();
        push_frames(1'b1, P6, 12'h0, 12'h0, 2);
        @(negedge clk);
        r1_mode = 1'b1; pattern_mode = P6; enable = 1'b1;
        repeat (6) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_vals("midrst");
        model_reset();
        rst = 1'b0;
        enable = 1'b0;
        run(1'b1, P6, 12'h0, 12'h0, 2, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ad9361_rx_pattern_gen.md
Name: ad9361_rx_pattern_gen

Overview:
Synthesizable single-clock source of AD9361 RX interface traffic. It produces the nibble-serialised rx_frame/rx_data stream that the axi_ad9361 RX path consumes, one 6-bit nibble per clock. It sits directly upstream of the LVDS receive pins. In simulation it drives the fmcomms2 system top through a DDR wrapper; in hardware it feeds internal loopback.
- Selectable sample patterns: ramp, constant, optional PN9.
- Supports 1R1T and 2R2T framing.

Parameters:
DATA_W, 12, sample width per I or Q word; must be 2*NIB_W
NIB_W, 6, width of rx_data nibble
RAMP_INIT, 12'h000, ramp counter value after reset

Ports:
clk  in  1  interface clock; one nibble per rising edge
rst  in  1  synchronous active-high reset
enable  in  1  run request; level-sensitive
r1_mode  in  1  1 = 1R1T framing, 0 = 2R2T framing
pattern_mode  in  2  00 ramp, 01 PN9, 10 constant, 11 reserved
const_i  in  12  I value for constant mode
const_q  in  12  Q value for constant mode
rx_frame  out  1  frame marker
rx_data  out  6  nibble, MSB half first
rx_valid  out  1  rx_frame/rx_data carry a live nibble
busy  out  1  state != IDLE
frame_cnt  out  16  completed frames since reset; wraps 0xFFFF->0

Behaviour:
- Reset: rx_frame=0, rx_data=0, rx_valid=0, busy=0, frame_cnt=0, ramp=RAMP_INIT, PN9 state=9'h1FF, state=IDLE, nibble index=0.
- State machine has three states: IDLE, RUN, STOP.
  - IDLE->RUN: on an edge with enable=1. At that same edge, r1_mode and pattern_mode are latched.
  - RUN->STOP: on an edge with enable=0. STOP finishes the current frame, then goes to IDLE.
  - STOP->RUN: if enable returns to 1 before the frame ends, the block goes back to RUN with no gap.
- Latency: with enable sampled at edge k, nibble 0 is registered onto the outputs at edge k+1, with rx_valid=1.
- 1R1T frame is 4 nibbles: I[11:6], I[5:0], Q[11:6], Q[5:0].
  - rx_frame=1 on the I nibbles, 0 on the Q nibbles.
- 2R2T frame is 8 nibbles: I0 msb, I0 lsb, Q0 msb, Q0 lsb, I1 msb, I1 lsb, Q1 msb, Q1 lsb.
  - rx_frame=1 on channel 0, 0 on channel 1.
- Frames are back-to-back with no idle nibbles while in RUN.
- Mode inputs are re-latched only on the last nibble of a frame. A mid-frame change never corrupts the current frame.
- Sample generation occurs once per frame:
  - Ramp: I0=ramp, Q0=~ramp, I1=ramp^12'h800, Q1=~I1. Ramp increments by 1 per frame modulo 4096 (4095->0).
  - PN9: x^9+x^5+1, advanced 12 steps per sample word, successive words taken in order I0,Q0,I1,Q1.
  - Constant: I0=I1=const_i, Q0=Q1=const_q; const inputs are sampled with the mode latch.
  - Reserved (11): all data nibbles are 0; framing is unaffected.
- frame_cnt increments on the edge that outputs the last nibble of each frame.
- Not in RUN/STOP: rx_valid=0 and rx_data=0. rx_frame keeps its last value, so there is no spurious edge.
- rst mid-frame: everything returns to reset values on that edge; the partial frame is abandoned.
- rst and enable both high: rst wins.

Optional Feature:
AD9361_PATGEN_PN_EN
- Defined: the PN9 generator and pattern_mode=01 are implemented.
- Undefined: the PN logic is absent, and mode 01 behaves exactly as reserved (data 0, framing intact).

Decomposition:
- Package ad9361_patgen_pkg holds:
  - the pattern_mode localparams (PAT_RAMP, PAT_PN9, PAT_CONST, PAT_RSVD);
  - the state enum (IDLE, RUN, STOP);
  - frame lengths (FRAME_NIB_1R=4, FRAME_NIB_2R=8);
  - PN9 seed and taps.
- One sub-module, ad9361_patgen_pn9: a 9-bit LFSR with an advance input, producing a 12-bit word per advance. It is instantiated only under AD9361_PATGEN_PN_EN.

Test Plan:
1. Reset release, enable=1, r1_mode=1, ramp -> first frame has rx_data 00,00,3F,3F and rx_frame 1,1,0,0; the next frame's I is 12'h001; frame_cnt=1 after 4 valid nibbles.
2. r1_mode=0, constant with const_i=12'hABC, const_q=12'h123 -> repeating nibbles 2A,3C,04,23,2A,3C,04,23 with rx_frame 1×4 then 0×4.
3. Ramp run of 4097 frames -> I wraps 0xFFF->0x000 with no skipped value; frame_cnt=4097.
4. enable dropped after nibble 1 of an 8-nibble frame -> remaining 6 nibbles emitted, then rx_valid=0 and busy=0. Re-asserting during STOP gives a continuous stream.
5. r1_mode toggled mid-frame -> current frame completes in the old framing; the new framing starts on the next frame boundary.
6. rst pulsed mid-frame together with enable=1 -> the next cycle shows all outputs at reset values. Under AD9361_PATGEN_PN_EN, the first PN9 word after the restart matches the seed-1FF golden model.
